// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan receiver.
// The hex table lists active-high gfedcba codes for nibbles 0..F.
package seg_pkg;
  localparam int SEG_W   = 12;
  localparam int DIG_N   = 4;
  localparam int SEL_LSB = 8;
  localparam int DP_BIT  = 7;
  localparam int PAT_W   = 7;

  localparam logic [PAT_W-1:0] HEX_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       blank;
    logic       bad;
  } slot_t;
endpackage

// File: rtl/seg_scan_rx_seg7_to_hex.sv
// Combinational decode of an active-high a..g pattern back to a hex nibble.
// An all-off pattern reads as blank; anything outside the table reads as bad.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [PAT_W-1:0] i_pat,
  output logic [3:0]       o_nibble,
  output logic             o_blank,
  output logic             o_bad
);
  always_comb begin
    o_nibble = '0;
    o_blank  = (i_pat == '0);
    o_bad    = !o_blank;
    for (int k = 0; k < 16; k++) begin
      if (i_pat == HEX_CODES[k]) begin
        o_nibble = 4'(k);
        o_bad    = 1'b0;
      end
    end
  end
endmodule

// File: rtl/seg_scan_rx.sv
// Receiver for the scanned 12-bit seven-segment bus: filters each slot for
// stability, decodes it, and publishes a full 4-digit frame once all slots are seen.
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2**20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg,
  output logic [15:0]      digits,
  output logic [3:0]       dps,
  output logic [3:0]       blank,
  output logic [3:0]       bad,
  output logic             frame_valid,
  output logic             sel_err,
  output logic             stale
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [SEG_W-1:0] r_seg_q;
  logic [7:0]       r_run;
  logic [DIG_N-1:0] r_seen;
  slot_t            r_shadow [DIG_N];
  logic             r_complete;
  logic [15:0]      r_digits;
  logic [3:0]       r_dps, r_blank, r_bad;
  logic             r_frame_valid, r_sel_err;
  logic [IW-1:0]    r_idle;

  logic             w_same, w_accept, w_one, w_multi, w_capture, w_complete;
  logic [7:0]       w_run_next;
  logic [DIG_N-1:0] w_sel, w_mask;
  logic [3:0]       w_nibble;
  logic             w_blank, w_bad;
  slot_t            w_slot;

  // run counts consecutive edges that sampled the same bus value into r_seg_q,
  // so accept lands on the edge where the STABLE_CYCLES-th sample is taken.
  assign w_same     = (seg == r_seg_q);
  assign w_run_next = w_same ? ((r_run == 8'hFF) ? r_run : r_run + 8'd1) : 8'd1;
  assign w_accept   = w_same && (r_run == 8'(STABLE_CYCLES - 1));

  assign w_sel      = ~r_seg_q[SEL_LSB +: DIG_N];
  assign w_one      = (w_sel != '0) && ((w_sel & (w_sel - 4'd1)) == '0);
  assign w_multi    = (w_sel != '0) && !w_one;
  assign w_capture  = w_accept && w_one;
  assign w_mask     = w_capture ? w_sel : '0;
  assign w_complete = w_capture && ((r_seen | w_mask) == '1);

  seg7_to_hex u_dec (
    .i_pat    (~r_seg_q[PAT_W-1:0]),
    .o_nibble (w_nibble),
    .o_blank  (w_blank),
    .o_bad    (w_bad)
  );

  assign w_slot = {w_nibble, ~r_seg_q[DP_BIT], w_blank, w_bad};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_q       <= '1;
      r_run         <= '0;
      r_seen        <= '0;
      r_complete    <= 1'b0;
      r_digits      <= '0;
      r_dps         <= '0;
      r_blank       <= '0;
      r_bad         <= '0;
      r_frame_valid <= 1'b0;
      r_sel_err     <= 1'b0;
      r_idle        <= IW'(TIMEOUT);
      for (int i = 0; i < DIG_N; i++) r_shadow[i] <= '0;
    end else begin
      r_seg_q       <= seg;
      r_run         <= w_run_next;
      r_sel_err     <= w_accept && w_multi;
      r_complete    <= w_complete;
      r_frame_valid <= r_complete;
      r_seen        <= w_complete ? '0 : (r_seen | w_mask);
      for (int i = 0; i < DIG_N; i++) begin
        if (w_mask[i]) r_shadow[i] <= w_slot;
      end
      // Publish one edge after the completing capture so its slot is included.
      if (r_complete) begin
        for (int i = 0; i < DIG_N; i++) begin
          r_digits[4*i +: 4] <= r_shadow[i].nibble;
          r_dps[i]           <= r_shadow[i].dp;
          r_blank[i]         <= r_shadow[i].blank;
          r_bad[i]           <= r_shadow[i].bad;
        end
      end
      if (w_capture)                    r_idle <= '0;
      else if (r_idle != IW'(TIMEOUT))  r_idle <= r_idle + IW'(1);
    end
  end

  assign digits      = r_digits;
  assign dps         = r_dps;
  assign blank       = r_blank;
  assign bad         = r_bad;
  assign frame_valid = r_frame_valid;
  assign sel_err     = r_sel_err;
  assign stale       = (r_idle == IW'(TIMEOUT));
endmodule

// File: tb/tb_seg_scan_rx.sv
// Bench for seg_scan_rx: directed scenarios plus random scanning, checked
// against a sample-level model of the bus and a frame scoreboard.
module tb_seg_scan_rx;
  localparam int S  = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] seg = 12'hFFF;
  logic [15:0] digits;
  logic [3:0]  dps, blank, bad;
  logic        frame_valid, sel_err, stale;

  seg_scan_rx #(.STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .digits(digits), .dps(dps),
    .blank(blank), .bad(bad), .frame_valid(frame_valid),
    .sel_err(sel_err), .stale(stale)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];
  int          due_q[$];
  int          sel_due_q[$];

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model state
  logic [11:0] m_cur;
  int          m_len;
  int          m_idle;
  logic [3:0]  m_seen;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dp, m_blank, m_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void decode(input logic [6:0] p, output logic [3:0] n,
                                 output logic bl, output logic bd);
    n  = 4'h0;
    bl = (p == 7'h00);
    bd = !bl;
    for (int k = 0; k < 16; k++) if (p == hex_tab[k]) begin n = 4'(k); bd = 1'b0; end
  endfunction

  task automatic model_reset();
    m_cur  = 12'hFFF;
    m_len  = 0;
    m_idle = TO;
    m_seen = 4'h0;
    m_dp = 4'h0; m_blank = 4'h0; m_bad = 4'h0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
  endtask

  // One sampled bus value per edge; a value becomes a slot event on its S-th consecutive sample.
  task automatic model_edge(input logic [11:0] v);
    logic [3:0] sel, n;
    logic bl, bd, captured;
    int idx, lows;
    captured = 1'b0;
    if (v == m_cur) begin
      if (m_len < 255) m_len++;
    end else begin
      m_cur = v;
      m_len = 1;
    end
    if (m_len == S) begin
      sel  = ~v[11:8];
      lows = $countones(sel);
      if (lows > 1) sel_due_q.push_back(cyc);
      else if (lows == 1) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
        decode(~v[6:0], n, bl, bd);
        m_nib[idx] = n; m_dp[idx] = ~v[7]; m_blank[idx] = bl; m_bad[idx] = bd;
        m_seen[idx] = 1'b1;
        captured = 1'b1;
        if (m_seen == 4'hF) begin
          exp_q.push_back({m_nib[3], m_nib[2], m_nib[1], m_nib[0], m_dp, m_blank, m_bad});
          due_q.push_back(cyc + 1);
          m_seen = 4'h0;
        end
      end
    end
    if (captured) m_idle = 0;
    else if (m_idle < TO) m_idle++;
  endtask

  // driver tasks
  task automatic step(input logic [11:0] v);
    seg = v;
    @(posedge clk);
    #1;
    model_edge(v);
    chk("stale", {31'd0, stale}, {31'd0, m_idle == TO});
  endtask

  task automatic hold(input logic [11:0] v, input int d);
    repeat (d) step(v);
  endtask

  task automatic slot(input int idx, input logic [7:0] segs);
    logic [3:0] sel_n;
    sel_n = ~(4'b0001 << idx);
    hold({sel_n, segs}, 8);
    hold(12'hFFF, 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg   = 12'hFFF;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_outs", {digits, dps, blank, bad, frame_valid, sel_err}, 32'd0);
    chk("reset_stale", {31'd0, stale}, 32'd1);
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard
  logic [27:0] mon_e;
  int          mon_d;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) chk("frame_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          chk("frame", {4'd0, digits, dps, blank, bad}, {4'd0, mon_e});
          chk("frame_time", cyc, mon_d);
        end
      end
      if (sel_err) begin
        if (sel_due_q.size() == 0) chk("sel_err_unexpected", 32'd1, 32'd0);
        else begin
          mon_d = sel_due_q.pop_front();
          chk("sel_err_time", cyc, mon_d);
        end
        chk("sel_err_with_frame", {31'd0, frame_valid}, 32'd0);
      end
    end
  end

  initial begin
    logic [11:0] v;
    logic [3:0]  sel_n;
    int          a, b;
    model_reset();
    do_reset();

    // idle bus after reset
    for (int i = 0; i < 100; i++) begin
      step(12'hFFF);
      chk("idle_outs", {digits, dps, blank, bad, frame_valid, sel_err}, 32'd0);
    end

    // frame "1234"
    slot(0, ~8'h06); slot(1, ~8'h5B); slot(2, ~8'h4F); slot(3, ~8'h66);
    chk("f1234_digits", {16'd0, digits}, 32'h4321);
    chk("f1234_blank_bad", {24'd0, blank, bad}, 32'd0);
    chk("f1234_stale", {31'd0, stale}, 32'd0);

    // glitch filter on digit 2
    slot(0, ~8'h3F); slot(1, ~8'h06);
    hold({4'b1011, ~8'h7F}, 3);
    hold({4'b1011, ~8'h39}, 8);
    hold(12'hFFF, 2);
    slot(3, ~8'h07);
    chk("glitch_digit2", {28'd0, digits[11:8]}, 32'hC);

    // illegal select in the middle of a frame
    slot(0, ~8'h7D); slot(1, ~8'h6F);
    hold({4'b1100, ~8'h06}, 6);
    hold(12'hFFF, 2);
    slot(2, ~8'h77); slot(3, ~8'h79);
    chk("illegal_digits", {16'd0, digits}, 32'hEA96);

    // bad pattern and decimal point
    slot(0, ~8'h06); slot(1, ~8'h49); slot(2, ~8'h5B); slot(3, ~8'h80);
    chk("dp3", {31'd0, dps[3]}, 32'd1);
    chk("blank3", {31'd0, blank[3]}, 32'd1);
    chk("bad1", {31'd0, bad[1]}, 32'd1);
    chk("bad1_nibble", {28'd0, digits[7:4]}, 32'd0);

    // stop scanning: stale must rise TO cycles after the last capture
    hold(12'hFFF, 80);
    chk("timeout_stale", {31'd0, stale}, 32'd1);

    // reset during a partial frame, then rescan in a different order
    slot(0, ~8'h07); slot(1, ~8'h07);
    chk("pre_reset_q", exp_q.size(), 32'd0);
    do_reset();
    slot(2, ~8'h7C); slot(3, ~8'h5E); slot(0, ~8'h7F); slot(1, ~8'h6F);
    chk("post_reset_digits", {16'd0, digits}, 32'hDB98);

    // random scanning with glitches, gaps, illegal selects and junk values
    for (int r = 0; r < 150; r++) begin
      a = $urandom_range(0, 9);
      if (a <= 6) sel_n = ~(4'b0001 << $urandom_range(0, 3));
      else if (a == 7) begin
        b = $urandom_range(0, 2);
        sel_n = ~((4'b0011 << b) | 4'b1000);
      end else sel_n = 4'hF;
      if ($urandom_range(0, 5) == 0) v = {sel_n, 8'($urandom_range(0, 255))};
      else v = {sel_n, 1'($urandom_range(0, 1)), ~hex_tab[$urandom_range(0, 15)]};
      if (a == 9) v = 12'($urandom_range(0, 4095));
      hold(v, $urandom_range(1, 7));
      hold(12'hFFF, $urandom_range(0, 3));
    end

    hold(12'hFFF, 6);
    chk("frames_drained", exp_q.size(), 32'd0);
    chk("sel_err_drained", sel_due_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
